// File: rtl/sub_nibbles_engine.sv
// ---------------------------------------------------------------------------
// sub_nibbles_engine
//
// Iterative S-AES nibble substitution. A captured word of NIBBLES nibbles is
// pushed through LANES S-box instances, one group of LANES nibbles per cycle,
// starting with the most-significant group. STEPS = NIBBLES/LANES cycles after
// acceptance the fully substituted word is presented with out_valid and held
// until the downstream takes it.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset (discards any word in flight)
//   in_valid   input word/mode valid
//   in_ready   engine can accept a word (registered)
//   in_data    word to substitute, nibble k = in_data[4k+3:4k]
//   in_inv     0 = forward S-box, 1 = inverse S-box (sampled at acceptance)
//   out_valid  result valid, held until accepted (registered)
//   out_ready  downstream accepts the result
//   out_data   substituted word (registered)
//   busy       high while a word is being processed or waiting to be taken
// ---------------------------------------------------------------------------
module sub_nibbles_engine #(
    parameter int NIBBLES = 4,
    parameter int LANES   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_data,
    output logic                 busy
);
    localparam int W     = 4 * NIBBLES;
    localparam int STEPS = NIBBLES / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Reject configurations where the lanes do not tile the word exactly.
    if (NIBBLES < 1 || LANES < 1 || (NIBBLES % LANES) != 0) begin : g_bad_cfg
        $error("sub_nibbles_engine: NIBBLES must be a positive multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg;
    logic [W-1:0]    work_reg;
    logic [W-1:0]    work_next;
    logic [W-1:0]    out_data_reg;
    logic            inv_reg;
    logic [CW-1:0]   cnt_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic            busy_reg;
    logic [3:0]      lane_in  [LANES];
    logic [3:0]      lane_out [LANES];
    int              grp_base;

    // Combined forward/inverse S-box lookup.
    function automatic logic [3:0] sbox(input logic [3:0] x, input logic inv);
        logic [3:0] y;
        case (x)
            4'h0:    y = inv ? 4'hA : 4'h9;
            4'h1:    y = inv ? 4'h5 : 4'h4;
            4'h2:    y = inv ? 4'h9 : 4'hA;
            4'h3:    y = inv ? 4'hB : 4'hB;
            4'h4:    y = inv ? 4'h1 : 4'hD;
            4'h5:    y = inv ? 4'h7 : 4'h1;
            4'h6:    y = inv ? 4'h8 : 4'h8;
            4'h7:    y = inv ? 4'hF : 4'h5;
            4'h8:    y = inv ? 4'h6 : 4'h6;
            4'h9:    y = inv ? 4'h0 : 4'h2;
            4'hA:    y = inv ? 4'h2 : 4'h0;
            4'hB:    y = inv ? 4'h3 : 4'h3;
            4'hC:    y = inv ? 4'hC : 4'hC;
            4'hD:    y = inv ? 4'h4 : 4'hE;
            4'hE:    y = inv ? 4'hD : 4'hF;
            default: y = inv ? 4'hE : 4'h7;
        endcase
        return y;
    endfunction

    // Step 0 handles the most-significant group, so the group index counts down
    // as the step counter counts up.
    always_comb begin
        grp_base = (STEPS - 1 - int'(cnt_reg)) * LANES;
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_in[gi]  = work_reg[(grp_base + gi) * 4 +: 4];
        assign lane_out[gi] = sbox(lane_in[gi], inv_reg);
    end

    always_comb begin
        work_next = work_reg;
        for (int l = 0; l < LANES; l++) begin
            work_next[(grp_base + l) * 4 +: 4] = lane_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            out_data_reg  <= '0;
            inv_reg       <= 1'b0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        work_reg     <= in_data;
                        inv_reg      <= in_inv;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    work_reg <= work_next;
                    if (cnt_reg == CW'(STEPS - 1)) begin
                        // Last group: publish the finished word directly.
                        out_data_reg  <= work_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_sub_nibbles_engine.sv
// ---------------------------------------------------------------------------
// tb_sub_nibbles_engine
//
// Three engine configurations (4/1, 4/4, 8/2) run side by side. Each has a
// transaction-level reference model (whole-word S-box lookup plus a countdown
// of STEPS edges), a per-cycle compare process, directed scenarios with
// hand-computed literal results, and a randomized phase with random resets.
// ---------------------------------------------------------------------------
module tb_sub_nibbles_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] FWD_T [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                         4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
    localparam logic [3:0] INV_T [16] = '{4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
                                         4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE};

    function automatic logic [31:0] subst(input logic [31:0] w, input int n, input logic inv);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            r[4*k +: 4] = inv ? INV_T[w[4*k +: 4]] : FWD_T[w[4*k +: 4]];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int N = (gi == 2) ? 8 : 4;
        localparam int L = (gi == 0) ? 1 : (gi == 1) ? 4 : 2;
        localparam int S = N / L;
        localparam int W = 4 * N;

        logic         rst       = 1'b1;
        logic         in_valid  = 1'b0;
        logic         in_inv    = 1'b0;
        logic         out_ready = 1'b0;
        logic [W-1:0] in_data   = '0;
        logic         in_ready;
        logic         out_valid;
        logic         busy;
        logic [W-1:0] out_data;
        bit           done_b = 1'b0;

        sub_nibbles_engine #(.NIBBLES(N), .LANES(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_inv    (in_inv),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .busy      (busy)
        );

        // Reference model: 0 = idle, 1 = working (m_left edges to go), 2 = holding result.
        int           m_phase = 0;
        int           m_left  = 0;
        logic [W-1:0] m_res   = '0;
        logic [W-1:0] m_out   = '0;

        always @(posedge clk) begin
            if (rst) begin
                m_phase <= 0;
                m_left  <= 0;
                m_out   <= '0;
            end else begin
                case (m_phase)
                    0: if (in_valid) begin
                        m_res   <= W'(subst(32'(in_data), N, in_inv));
                        m_left  <= S;
                        m_phase <= 1;
                    end
                    1: if (m_left == 1) begin
                        m_phase <= 2;
                        m_out   <= m_res;
                    end else begin
                        m_left <= m_left - 1;
                    end
                    default: if (out_ready) m_phase <= 0;
                endcase
            end
        end

        always @(negedge clk) begin
            check($sformatf("cfg%0d in_ready", gi),  32'(in_ready),  32'(m_phase == 0));
            check($sformatf("cfg%0d out_valid", gi), 32'(out_valid), 32'(m_phase == 2));
            check($sformatf("cfg%0d busy", gi),      32'(busy),      32'(m_phase != 0));
            check($sformatf("cfg%0d out_data", gi),  32'(out_data),  32'(m_out));
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic do_reset();
            rst = 1'b1;
            in_valid = 1'b0;
            out_ready = 1'b0;
            tick();
            tick();
            check($sformatf("cfg%0d reset in_ready", gi),  32'(in_ready),  32'd1);
            check($sformatf("cfg%0d reset out_valid", gi), 32'(out_valid), 32'd0);
            check($sformatf("cfg%0d reset busy", gi),      32'(busy),      32'd0);
            check($sformatf("cfg%0d reset out_data", gi),  32'(out_data),  32'd0);
            rst = 1'b0;
        endtask

        // Present a word and return one time unit after the accepting edge.
        task automatic accept(input logic [W-1:0] d, input logic m);
            int t;
            in_valid = 1'b1;
            in_data  = d;
            in_inv   = m;
            t = 0;
            while (!in_ready && t < 100) begin
                tick();
                t++;
            end
            check($sformatf("cfg%0d accept timeout", gi), 32'(t < 100), 32'd1);
            tick();
            in_valid = 1'b0;
        endtask

        task automatic wait_valid(output int lat);
            lat = 0;
            while (!out_valid && lat < 200) begin
                tick();
                lat++;
            end
        endtask

        task automatic consume();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        endtask

        task automatic run(input logic [W-1:0] d, input logic m,
                           output logic [W-1:0] r, output int lat);
            accept(d, m);
            wait_valid(lat);
            r = out_data;
            consume();
        endtask

        task automatic random_phase();
            for (int c = 0; c < 400; c++) begin
                tick();
                rst       = ($urandom_range(0, 49) == 0);
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = W'($urandom);
                in_inv    = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
            rst = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b1;
            repeat (S + 4) tick();
            done_b = 1'b1;
        endtask

        if (gi == 0) begin : g_dir
            initial begin
                logic [W-1:0] r;
                logic [W-1:0] back;
                logic [W-1:0] w;
                int lat;
                bit seen;
                do_reset();
                // T1
                run(16'h1234, 1'b0, r, lat);
                check("T1 data", 32'(r), 32'h4ABD);
                check("T1 latency", 32'(lat), 32'd4);
                check("T1 in_ready after take", 32'(in_ready), 32'd1);
                // T2
                run(16'h4ABD, 1'b1, r, lat);
                check("T2 inverse data", 32'(r), 32'h1234);
                for (int k = 0; k < 4; k++) begin
                    w = 16'h0123 + 16'(k) * 16'h4444;
                    run(w, 1'b0, r, lat);
                    run(r, 1'b1, back, lat);
                    check($sformatf("T2 roundtrip %h", w), 32'(back), 32'(w));
                end
                // T5
                accept(16'h1234, 1'b0);
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                seen = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    if (out_valid) seen = 1'b1;
                    tick();
                end
                check("T5 no result after reset", 32'(seen), 32'd0);
                run(16'h0000, 1'b0, r, lat);
                check("T5 next word", 32'(r), 32'h9999);
                // T6
                accept(16'h1234, 1'b0);
                lat = 0;
                while (!out_valid && lat < 50) begin
                    in_data = W'($urandom);
                    in_inv  = ~in_inv;
                    tick();
                    lat++;
                end
                check("T6 data", 32'(out_data), 32'h4ABD);
                check("T6 latency", 32'(lat), 32'd4);
                consume();
                random_phase();
            end
        end else if (gi == 1) begin : g_dir
            initial begin
                int lat;
                do_reset();
                // T3
                accept(16'hFEDC, 1'b0);
                wait_valid(lat);
                check("T3 latency", 32'(lat), 32'd1);
                check("T3 data", 32'(out_data), 32'h7FEC);
                in_valid = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    check("T3 in_ready held low", 32'(in_ready), 32'd0);
                    tick();
                end
                in_valid = 1'b0;
                consume();
                check("T3 in_ready after take", 32'(in_ready), 32'd1);
                random_phase();
            end
        end else begin : g_dir
            initial begin
                int lat;
                do_reset();
                // T4
                accept(32'h01234567, 1'b0);
                wait_valid(lat);
                check("T4 latency", 32'(lat), 32'd4);
                check("T4 data", 32'(out_data), 32'h94ABD185);
                for (int c = 0; c < 5; c++) begin
                    tick();
                    check("T4 held valid", 32'(out_valid), 32'd1);
                    check("T4 held data", 32'(out_data), 32'h94ABD185);
                end
                consume();
                check("T4 out_valid after take", 32'(out_valid), 32'd0);
                check("T4 in_ready after take", 32'(in_ready), 32'd1);
                random_phase();
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g[0].done_b && g[1].done_b && g[2].done_b) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check("bench completion", 32'(g[0].done_b && g[1].done_b && g[2].done_b), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
